// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch stage.
package inst_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    // Canonical NOP (addi x0, x0, 0); also the power-on content of fetch buffer slots.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small flushable FIFO holding {pc, inst} pairs between imem and the decoder.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests and
// hands {inst, pc} to the decoder through a flushable FIFO.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   resp_pc;
    logic [XLEN-1:0]   target;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW:0]       inflight;
    logic              fire;
    logic              keep;
    logic              pop;
    logic [2*XLEN-1:0] head;

    assign target   = {redirect_pc[XLEN-1:2], 2'b00};
    // Buffered plus outstanding words never exceed DEPTH, so every response has a slot.
    assign inflight = {1'b0, count} + {1'b0, outstanding};

    assign imem_req_valid = rst_n && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign keep           = imem_resp_valid && !redirect_valid && (discard == '0);

    assign out_valid         = (count != '0) && !redirect_valid;
    assign pop               = out_valid && out_ready;
    assign {out_pc, out_inst} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            // Words still owed by imem belong to the old path; drop them on arrival.
            pc          <= target;
            resp_pc     <= target;
            outstanding <= outstanding - CW'(imem_resp_valid);
            discard     <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (fire) pc <= pc + XLEN'(4);
            if (keep) resp_pc <= resp_pc + XLEN'(4);
            if (imem_resp_valid && discard != '0) discard <= discard - CW'(1);
            outstanding <= outstanding + CW'(fire) - CW'(imem_resp_valid);
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH),
        .INIT  ({RESET_PC, XLEN'(INST_NOP)})
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (keep),
        .pop   (pop),
        .wdata ({resp_pc, imem_resp_data}),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: 1-cycle imem model with response hold control and an in-order scoreboard.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic        mem_hold = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          n_fire = 0;
    int          n_acc = 0;
    int          n_rsp = 0;
    int          base;
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];

    localparam logic [31:0] MAGIC = 32'h1357_9BDF;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pop one entry from a full buffer, then let the fetch stage refill it.
    task automatic pulse(input logic [31:0] pc);
        exp_q.push_back(pc);
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        repeat (6) cyc();
    endtask

    // Instruction memory: content is addr ^ MAGIC, responses one cycle after acceptance.
    initial begin : imem_model
        logic        fire_now;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (imem_resp_valid) begin
                assert (n_acc > n_rsp) else $error("imem response with nothing outstanding");
                n_rsp++;
            end
            fire_now = rst_n && imem_req_valid && imem_req_ready;
            a = imem_req_addr;
            if (fire_now) n_acc++;
            @(posedge clk);
            #2;
            if (fire_now) begin
                mq.push_back(a);
                n_fire++;
            end
            if (mq.size() > 0 && !mem_hold) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mq.pop_front() ^ MAGIC;
            end else begin
                imem_resp_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got pc %h with nothing expected", out_pc);
                end else begin
                    w = exp_q.pop_front();
                    chk("out_pc", out_pc, w);
                    chk("out_inst", out_inst, w ^ MAGIC);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        // Release with the decoder stalled: exactly two words fetched, head parks at 0x0.
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c0_req_addr", imem_req_addr, 32'h0);
        chk("c0_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("c1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("c2_out_valid", 32'(out_valid), 32'd1);
        chk("c2_out_pc", out_pc, 32'h0);
        repeat (7) @(negedge clk);
        chk("stall_fires", 32'(n_fire), 32'd2);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_out_pc", out_pc, 32'h0);

        pulse(32'h0);
        pulse(32'h4);
        pulse(32'h8);

        // Drain the buffer with imem stalled so 0x14 and 0x18 are in flight, then redirect.
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        cyc();
        out_ready = 1'b1;
        mem_hold  = 1'b1;
        base      = n_fire;
        cyc();
        cyc();
        cyc();
        out_ready = 1'b0;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        chk("inflight_two", 32'(n_fire - base), 32'd2);
        chk("rd1_out_valid", 32'(out_valid), 32'd0);
        chk("rd1_req_valid", 32'(imem_req_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        repeat (8) cyc();
        pulse(32'h100);
        pulse(32'h104);

        // Redirect from a full buffer; low address bits are ignored.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        chk("rd2_out_valid", 32'(out_valid), 32'd0);
        chk("rd2_req_valid", 32'(imem_req_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd2_next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd2_next_req_addr", imem_req_addr, 32'h200);
        repeat (6) cyc();
        pulse(32'h200);

        // Redirect coinciding with the only outstanding response.
        exp_q.push_back(32'h204);
        cyc();
        out_ready = 1'b1;
        mem_hold  = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        mem_hold       = 1'b0;
        @(negedge clk);
        chk("rd3_out_valid", 32'(out_valid), 32'd0);
        chk("rd3_req_valid", 32'(imem_req_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd3_next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd3_next_req_addr", imem_req_addr, 32'h300);
        repeat (6) cyc();
        pulse(32'h300);

        // Redirect while a slot is free (request would otherwise fire), then PC wrap.
        exp_q.push_back(32'h304);
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("rd4_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rd4_out_valid", 32'(out_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd4_next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd4_next_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        repeat (6) cyc();
        pulse(32'hFFFF_FFFC);
        pulse(32'h0);

        repeat (4) cyc();
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
